// File: rtl/booth_seq_mul_if.sv
// booth_seq_mul_if: operand/result bundle for the radix-4 Booth multiplier.
// UNSIGNED_MUL_EN adds the mul_unsigned mode select.
interface booth_seq_mul_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] product_hi;
    logic [WIDTH-1:0] product_lo;
`ifdef UNSIGNED_MUL_EN
    logic             mul_unsigned;

    modport master (
        output start, multiplicand, multiplier, mul_unsigned,
        input  busy, done, product_hi, product_lo
    );
    modport slave (
        input  start, multiplicand, multiplier, mul_unsigned,
        output busy, done, product_hi, product_lo
    );
`else
    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, product_hi, product_lo
    );
    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, product_hi, product_lo
    );
`endif
endinterface

// File: rtl/booth_seq_mul.sv
// booth_seq_mul: sequential radix-4 Booth multiplier, one bit pair per clock.
// UNSIGNED_MUL_EN adds an unsigned mode with one extra iteration.
module booth_seq_mul #(
    parameter int WIDTH = 32
) (
    input logic          Clock,
    input logic          Clear,
    booth_seq_mul_if.slave bus
);
    localparam int W   = WIDTH;
    localparam int AW  = W + 2;
    localparam int N_S = W / 2;
`ifdef UNSIGNED_MUL_EN
    // Q is widened so the extra pair sees zero-extension bits.
    localparam int QW   = W + 2;
    localparam int N_U  = W / 2 + 1;
    localparam int NMAX = N_U;
`else
    localparam int QW   = W;
    localparam int NMAX = N_S;
`endif
    localparam int CW = $clog2(NMAX);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    logic [AW-1:0]   m;
    logic [AW-1:0]   a;
    logic [QW-1:0]   q;
    logic            qm1;
    logic [CW-1:0]   cnt;
    logic            busy_r;
    logic            done_r;
    logic [W-1:0]    hi_r;
    logic [W-1:0]    lo_r;
`ifdef UNSIGNED_MUL_EN
    logic            uns;
`endif

    logic [AW-1:0]   m_ld;
    logic [QW-1:0]   q_ld;
    logic [CW-1:0]   cnt_ld;
    logic [AW-1:0]   m2;
    logic [AW-1:0]   addend;
    logic [AW-1:0]   sum;
    logic [AW-1:0]   a_nx;
    logic [QW-1:0]   q_nx;
    logic [W-1:0]    res_hi;
    logic [W-1:0]    res_lo;

    // Operand extension and iteration count for a new capture.
    always_comb begin
`ifdef UNSIGNED_MUL_EN
        if (bus.mul_unsigned) begin
            m_ld   = {2'b00, bus.multiplicand};
            q_ld   = {2'b00, bus.multiplier};
            cnt_ld = CW'(N_U - 1);
        end else begin
            m_ld   = {{2{bus.multiplicand[W-1]}}, bus.multiplicand};
            q_ld   = {{2{bus.multiplier[W-1]}}, bus.multiplier};
            cnt_ld = CW'(N_S - 1);
        end
`else
        m_ld   = {{2{bus.multiplicand[W-1]}}, bus.multiplicand};
        q_ld   = bus.multiplier;
        cnt_ld = CW'(N_S - 1);
`endif
    end

    assign m2 = {m[AW-2:0], 1'b0};

    // Booth recoding of {Q1,Q0,Q-1} into the partial-product addend.
    always_comb begin
        addend = '0;
        case ({q[1:0], qm1})
            3'b001, 3'b010: addend = m;
            3'b011:         addend = m2;
            3'b100:         addend = -m2;
            3'b101, 3'b110: addend = -m;
            default:        addend = '0;
        endcase
    end

    // Accumulate, then arithmetic shift {A,Q,Q-1} right by two.
    always_comb begin
        sum  = a + addend;
        a_nx = {{2{sum[AW-1]}}, sum[AW-1:2]};
        q_nx = {sum[1:0], q[QW-1:2]};
    end

    // Product alignment after the final shift.
    always_comb begin
`ifdef UNSIGNED_MUL_EN
        if (uns) begin
            res_hi = {a_nx[W-3:0], q_nx[W+1:W]};
            res_lo = q_nx[W-1:0];
        end else begin
            res_hi = a_nx[W-1:0];
            res_lo = q_nx[W+1:2];
        end
`else
        res_hi = a_nx[W-1:0];
        res_lo = q_nx;
`endif
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state  <= IDLE;
            m      <= '0;
            a      <= '0;
            q      <= '0;
            qm1    <= 1'b0;
            cnt    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
`ifdef UNSIGNED_MUL_EN
            uns    <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        m      <= m_ld;
                        q      <= q_ld;
                        a      <= '0;
                        qm1    <= 1'b0;
                        cnt    <= cnt_ld;
`ifdef UNSIGNED_MUL_EN
                        uns    <= bus.mul_unsigned;
`endif
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    a   <= a_nx;
                    q   <= q_nx;
                    qm1 <= q[1];
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        hi_r   <= res_hi;
                        lo_r   <= res_lo;
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.product_hi = hi_r;
    assign bus.product_lo = lo_r;
endmodule

// File: tb/tb_booth_seq_mul.sv
// tb_booth_seq_mul: randomized and directed checks of booth_seq_mul
// against an arithmetic reference product.
module tb_booth_seq_mul;
    logic Clock;
    logic Clear;
    int   total;
    int   bad;

    booth_seq_mul_if #(.WIDTH(32)) bus ();

    booth_seq_mul #(.WIDTH(32)) dut (
        .Clock (Clock),
        .Clear (Clear),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [63:0] ref_mul(
        input logic [31:0] mv,
        input logic [31:0] qv,
        input bit          uns
    );
        longint          sm;
        longint          sq;
        longint unsigned um;
        longint unsigned uq;
        if (uns) begin
            um = {32'b0, mv};
            uq = {32'b0, qv};
            return um * uq;
        end
        sm = longint'($signed(mv));
        sq = longint'($signed(qv));
        return sm * sq;
    endfunction

    task automatic drive_start(
        input logic [31:0] mv,
        input logic [31:0] qv,
        input bit          uns
    );
        bus.start        = 1'b1;
        bus.multiplicand = mv;
        bus.multiplier   = qv;
`ifdef UNSIGNED_MUL_EN
        bus.mul_unsigned = uns;
`else
        if (uns) $display("note: unsigned request ignored in signed build");
`endif
    endtask

    // Start one operation and wait (bounded) for done.
    task automatic run_op(
        input  logic [31:0] mv,
        input  logic [31:0] qv,
        input  bit          uns,
        output logic [63:0] prod,
        output int          lat,
        output int          bcnt,
        output bit          ok
    );
        @(negedge Clock);
        drive_start(mv, qv, uns);
        @(posedge Clock);
        #1;
        bus.start = 1'b0;
        lat  = 0;
        bcnt = bus.busy ? 1 : 0;
        ok   = 1'b1;
        while (bus.done !== 1'b1) begin
            if (lat >= 40) begin
                ok = 1'b0;
                break;
            end
            @(posedge Clock);
            #1;
            lat++;
            if (bus.busy === 1'b1) bcnt++;
        end
        prod = {bus.product_hi, bus.product_lo};
    endtask

    task automatic test_reset;
        Clear            = 1'b0;
        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
`ifdef UNSIGNED_MUL_EN
        bus.mul_unsigned = 1'b0;
`endif
        #12;
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: busy=%b done=%b want 0 0",
                     bus.busy, bus.done);
        end
        total++;
        if ({bus.product_hi, bus.product_lo} !== 64'd0) begin
            bad++;
            $display("FAIL reset_product: got %h want 0",
                     {bus.product_hi, bus.product_lo});
        end
        @(negedge Clock);
        Clear = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_directed;
        logic [31:0] mv [3];
        logic [31:0] qv [3];
        logic [63:0] ev [3];
        logic [63:0] p;
        int          lat;
        int          bc;
        bit          ok;
        mv[0] = 32'hFFFF1B45; qv[0] = 32'd7654;
        ev[0] = 64'hFFFFFFFF_E54950FE;
        mv[1] = 32'h80000000; qv[1] = 32'h80000000;
        ev[1] = 64'h40000000_00000000;
        mv[2] = 32'h7FFFFFFF; qv[2] = 32'hFFFFFFFF;
        ev[2] = 64'hFFFFFFFF_80000001;
        for (int i = 0; i < 3; i++) begin
            run_op(mv[i], qv[i], 1'b0, p, lat, bc, ok);
            total++;
            if (!ok || lat != 16) begin
                bad++;
                $display("FAIL dir%0d_latency: got %0d want 16 ok=%0b",
                         i, lat, ok);
            end
            total++;
            if (bc != 16) begin
                bad++;
                $display("FAIL dir%0d_busy_cycles: got %0d want 16", i, bc);
            end
            total++;
            if (p !== ev[i]) begin
                bad++;
                $display("FAIL dir%0d_product: got %h want %h", i, p, ev[i]);
            end
        end
        repeat (3) @(posedge Clock);
        #1;
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 ||
            {bus.product_hi, bus.product_lo} !== ev[2]) begin
            bad++;
            $display("FAIL hold_after_done: done=%b busy=%b prod=%h want 0 0 %h",
                     bus.done, bus.busy, {bus.product_hi, bus.product_lo},
                     ev[2]);
        end
    endtask

    task automatic test_random;
        logic [31:0] mv;
        logic [31:0] qv;
        logic [63:0] p;
        logic [63:0] e;
        int          lat;
        int          bc;
        int          want;
        bit          ok;
        bit          uns;
        for (int i = 0; i < 40; i++) begin
            mv = $urandom;
            qv = $urandom;
            if (i % 8 == 1) mv = 32'd0;
            if (i % 8 == 3) qv = 32'hFFFFFFFF;
            if (i % 8 == 5) mv = 32'h80000000;
            uns = 1'b0;
`ifdef UNSIGNED_MUL_EN
            uns = 1'($urandom_range(0, 1));
`endif
            want = uns ? 17 : 16;
            e = ref_mul(mv, qv, uns);
            run_op(mv, qv, uns, p, lat, bc, ok);
            total++;
            if (!ok || lat != want || p !== e) begin
                bad++;
                $display("FAIL rand%0d: m=%h q=%h u=%0b got %h lat %0d want %h lat %0d",
                         i, mv, qv, uns, p, lat, e, want);
            end
        end
    endtask

    task automatic test_back_to_back;
        int   lat;
        bit   ok;
        @(negedge Clock);
        drive_start(32'd7, 32'd6, 1'b0);
        @(posedge Clock);
        #1;
        bus.start = 1'b0;
        lat = 0;
        repeat (3) begin
            @(posedge Clock);
            lat++;
        end
        @(negedge Clock);
        drive_start(32'd3, 32'd3, 1'b0);
        repeat (2) begin
            @(posedge Clock);
            lat++;
        end
        #1;
        bus.start = 1'b0;
        bus.multiplicand = 32'h12345678;
        bus.multiplier   = 32'h9ABCDEF0;
        ok = 1'b1;
        while (bus.done !== 1'b1) begin
            if (lat >= 40) begin
                ok = 1'b0;
                break;
            end
            @(posedge Clock);
            #1;
            lat++;
        end
        total++;
        if (!ok || lat != 16) begin
            bad++;
            $display("FAIL ignore_latency: got %0d want 16 ok=%0b", lat, ok);
        end
        total++;
        if ({bus.product_hi, bus.product_lo} !== 64'd42) begin
            bad++;
            $display("FAIL ignore_product: got %h want 42",
                     {bus.product_hi, bus.product_lo});
        end
        drive_start(32'd3, 32'd3, 1'b0);
        @(posedge Clock);
        #1;
        bus.start = 1'b0;
        bus.multiplicand = 32'hDEADBEEF;
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_restart: done=%b busy=%b want 0 1",
                     bus.done, bus.busy);
        end
        lat = 0;
        ok  = 1'b1;
        while (bus.done !== 1'b1) begin
            if (lat >= 40) begin
                ok = 1'b0;
                break;
            end
            @(posedge Clock);
            #1;
            lat++;
        end
        total++;
        if (!ok || lat != 16 || {bus.product_hi, bus.product_lo} !== 64'd9) begin
            bad++;
            $display("FAIL b2b_product: got %h lat %0d want 9 lat 16",
                     {bus.product_hi, bus.product_lo}, lat);
        end
    endtask

    task automatic test_reset_mid;
        logic [63:0] p;
        logic [63:0] e;
        int          lat;
        int          bc;
        bit          ok;
        bit          seen;
        @(negedge Clock);
        drive_start(32'hFFFF1B45, 32'd7654, 1'b0);
        @(posedge Clock);
        #1;
        bus.start = 1'b0;
        repeat (8) @(posedge Clock);
        #1;
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_busy_before: got %b want 1", bus.busy);
        end
        #1;
        Clear = 1'b0;
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            {bus.product_hi, bus.product_lo} !== 64'd0) begin
            bad++;
            $display("FAIL mid_reset_async: busy=%b done=%b prod=%h want 0 0 0",
                     bus.busy, bus.done, {bus.product_hi, bus.product_lo});
        end
        seen = 1'b0;
        repeat (2) begin
            @(posedge Clock);
            #1;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
        end
        @(negedge Clock);
        Clear = 1'b1;
        repeat (20) begin
            @(posedge Clock);
            #1;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL mid_no_done: activity seen=1 want 0");
        end
        e = ref_mul(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0);
        run_op(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, p, lat, bc, ok);
        total++;
        if (!ok || lat != 16 || p !== e) begin
            bad++;
            $display("FAIL mid_fresh: got %h lat %0d want %h lat 16",
                     p, lat, e);
        end
    endtask

`ifdef UNSIGNED_MUL_EN
    task automatic test_unsigned;
        logic [63:0] p;
        int          lat;
        int          bc;
        bit          ok;
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, p, lat, bc, ok);
        total++;
        if (!ok || lat != 17 || bc != 17) begin
            bad++;
            $display("FAIL uns_latency: got %0d busy %0d want 17", lat, bc);
        end
        total++;
        if (p !== 64'hFFFFFFFE_00000001) begin
            bad++;
            $display("FAIL uns_product: got %h want fffffffe00000001", p);
        end
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, p, lat, bc, ok);
        total++;
        if (!ok || lat != 16 || p !== 64'd1) begin
            bad++;
            $display("FAIL uns_off_signed: got %h lat %0d want 1 lat 16",
                     p, lat);
        end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
`ifdef UNSIGNED_MUL_EN
        test_unsigned();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/booth_seq_mul.md
Name: booth_seq_mul

Overview:
- Sequential radix-4 (bit-pair recoded) Booth multiplier.
- Operands: Y register output (multiplicand) and bus value (multiplier). The 64-bit product feeds the ZHigh/ZLow register pair, and from there HI/LO.
- Started by the control step that decodes MUL.
- Control holds in its T4 step until done pulses, then proceeds to ZLowIn/ZHighIn capture.

Parameters:
- WIDTH, 32: operand width in bits. Must be even and ≥4. Product is 2*WIDTH.

Ports:
- Clock  in  1  system clock, rising-edge.
- Clear  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- multiplicand  in  WIDTH  M operand (from Y).
- multiplier  in  WIDTH  Q operand (from bus).
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse: product valid.
- product_hi  out  WIDTH  upper half of product (to ZHigh).
- product_lo  out  WIDTH  lower half of product (to ZLow).
- mul_unsigned  in  1  present only with UNSIGNED_MUL_EN.

Behaviour:
- Reset: Clear low forces, immediately and asynchronously, the following to 0:
  - state = IDLE
  - busy, done, product_hi, product_lo
  - accumulator, multiplier shift register, Q[-1] bit, iteration counter
- Reset mid-operation aborts it; no done is produced.
- States:
  - IDLE: start=1 at edge k → RUN. Capture M and Q; A=0, Q[-1]=0; counter = N-1 where N = WIDTH/2 (signed). busy=1 after edge k.
  - RUN: each edge performs one iteration:
    - Examine {Q[1],Q[0],Q[-1]}:
      - 000 or 111 → +0
      - 001 or 010 → +M
      - 011 → +2M
      - 100 → −2M
      - 101 or 110 → −M
    - Then arithmetic-shift {A,Q,Q[-1]} right by 2.
    - Counter decrements. The edge at which counter==0 is the last iteration; that edge → DONE.
  - DONE:
    - Entered with product_hi/product_lo loaded from {A,Q}, done=1, busy=0.
    - Next edge: done=0. If start=1 → RUN with new capture (back-to-back allowed); else → IDLE.
- Latency: start captured at edge k; done high and product valid after edge k+N (k+16 for WIDTH=32).
- Arithmetic:
  - A is WIDTH+2 bits signed; M is sign-extended to WIDTH+2; 2M is M shifted left by 1.
  - All sums wrap within WIDTH+2 bits. No overflow is possible by construction.
- Result is the exact two's-complement 2*WIDTH product for all inputs, including M = Q = most-negative value.
- product_hi/product_lo change only when entering DONE and hold until the next DONE or reset.
- start while in RUN: ignored, with no effect on the current operation.
- Operand inputs are sampled only at the capture edge; later changes are ignored.

Optional Feature:
- Macro: UNSIGNED_MUL_EN.
- Defined:
  - mul_unsigned port exists, sampled with start.
  - When mul_unsigned=1: M and Q are zero-extended to WIDTH+2; N = WIDTH/2+1, so latency is k+17 at WIDTH=32; result is the unsigned product.
  - When mul_unsigned=0: behaviour is identical to signed mode.
- Undefined: port absent, signed-only, fixed N = WIDTH/2.

Test Plan:
- Signed mixed-sign product:
  - Stimulus: Clear pulse; M=-58555 (0xFFFF1B45), Q=7654; start at edge k.
  - Response: busy high for 16 cycles; done pulse after edge k+16; product_hi=0xFFFFFFFF, product_lo=0xE54950FE.
- Most-negative corner: M=Q=0x80000000 → product_hi=0x40000000, product_lo=0x00000000.
- Max-positive times −1: M=0x7FFFFFFF, Q=0xFFFFFFFF → product_hi=0xFFFFFFFF, product_lo=0x80000001.
- Ignored start and operand stability:
  - Stimulus: start 7*6; re-assert start with 3*3 and change operands during RUN; after done, start 3*3 in the DONE cycle.
  - Response: first result 42, with the RUN-time start and operand changes ignored; second operation starts back-to-back and gives 9.
- Reset mid-operation: Clear low at RUN iteration 8 → all outputs 0 immediately, state IDLE, no done. A fresh start afterwards gives the correct product.
- Unsigned mode (UNSIGNED_MUL_EN defined): mul_unsigned=1, M=Q=0xFFFFFFFF → done after 17 edges; product_hi=0xFFFFFFFE, product_lo=0x00000001.
